// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Imported by the top level and by the round-robin grant block.
package imem_arb_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int DW_DEF    = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between fetch and loader.
// en masks the fetch requester so the loader can own memory during boot.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic gclk_unused_tie,
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic f_req,
    input  logic l_req,
    output logic f_gnt,
    output logic l_gnt
);

    req_e last;

    // Under contention the requester that was not served last wins.
    always_comb begin
        f_gnt = en & f_req & (~l_req | (last == REQ_LOAD));
        l_gnt = l_req & ~f_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= REQ_LOAD;
        else if (f_gnt)
            last <= REQ_FETCH;
        else if (l_gnt)
            last <= REQ_LOAD;
    end

    logic unused_ok;
    assign unused_ok = gclk_unused_tie;

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: boot-phase loader ownership, then round-robin
// sharing between fetch and loader with registered one-cycle read data.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = DW_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_rdata,

    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_done,
    output logic          l_gnt,
    output logic          l_valid,
    output logic [DW-1:0] l_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic          cpu_stall,
    output logic [AW:0]   boot_count
);

    localparam logic [AW:0] BC_MAX = (AW+1)'(DEPTH);

    arb_state_e state, state_nxt;
    logic       boot_wr;

    rr_arb2 u_rr (
        .gclk_unused_tie (1'b0),
        .clk             (clk),
        .reset_n         (reset_n),
        .en              (state == RUN),
        .f_req           (f_req),
        .l_req           (l_req),
        .f_gnt           (f_gnt),
        .l_gnt           (l_gnt)
    );

    assign boot_wr   = (state == BOOT) & l_gnt & l_we;
    assign cpu_stall = (state == BOOT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // l_done and the final write may coincide; either leaves exactly one exit.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: if (l_done || (boot_wr && boot_count == BC_MAX - 1'b1))
                      state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            boot_count <= '0;
        else if (boot_wr && boot_count != BC_MAX)
            boot_count <= boot_count + 1'b1;
    end

    always_comb begin
        mem_a = '0;
        if (f_gnt)
            mem_a = f_addr;
        else if (l_gnt)
            mem_a = l_addr;
    end

    assign mem_we = l_gnt & l_we;
    assign mem_wd = l_wdata;

    // Read data is captured at the end of the grant cycle; rdata holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_valid <= 1'b0;
            l_valid <= 1'b0;
            f_rdata <= '0;
            l_rdata <= '0;
        end else begin
            f_valid <= f_gnt;
            l_valid <= l_gnt & ~l_we;
            if (f_gnt)
                f_rdata <= mem_rd;
            if (l_gnt && !l_we)
                l_rdata <= mem_rd;
        end
    end

endmodule
